// File: rtl/encoder_pkg.sv
// Shared types and constants for the 16-line priority encoder queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package encoder_pkg;

   localparam int N_LINES = 16;
   localparam int CODE_W  = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   // One-hot mask of a line index, used to retire the bit being offered.
   function automatic logic [N_LINES-1:0] onehot(input logic [CODE_W-1:0] idx);
      logic [N_LINES-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/prio_sel16.sv
// Combinational priority selector: index of the winning set bit of a 16-bit vector.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   i_vec  - candidate vector, bit i = line i
//   o_idx  - winning index (0 when i_vec is empty)
//   o_any  - at least one bit of i_vec is set
module prio_sel16
   import encoder_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic [N_LINES-1:0] i_vec,
   output logic [CODE_W-1:0]  o_idx,
   output logic               o_any
);

   // Scan in the direction opposite to priority so the last hit is the winner.
   always_comb begin
      o_idx = '0;
      if (LSB_FIRST) begin
         for (int i = N_LINES - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
               o_idx = CODE_W'(i);
            end
         end
      end else begin
         for (int i = 0; i < N_LINES; i++) begin
            if (i_vec[i]) begin
               o_idx = CODE_W'(i);
            end
         end
      end
   end

   assign o_any = |i_vec;

endmodule

// File: rtl/encoder164_queue.sv
// Sticky 16-line request capture with prioritised, handshaked index offers.
// Latency: req sampled at edge N into an empty idle queue is offered after edge N+1.
// Backpressure: ready=0 holds code/valid stable; ready=1 sustains one transfer per cycle.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   sta, stb, stc - capture enable = sta & ~stb & ~stc
//   req           - request lines, captured into pend while enabled
//   code, valid   - offered index and its qualifier (code is 0 when valid=0)
//   ready         - consumer accepts the current offer
//   gs            - some request is pending (from pend, not req)
module encoder164_queue
   import encoder_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sta,
   input  logic               stb,
   input  logic               stc,
   input  logic [N_LINES-1:0] req,
   output logic [CODE_W-1:0]  code,
   output logic               valid,
   input  logic               ready,
   output logic               gs
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [N_LINES-1:0]  r_pend;
   logic [N_LINES-1:0]  w_pend_nxt;
   logic [N_LINES-1:0]  w_clr;
   logic [CODE_W-1:0]   r_code;
   logic [CODE_W-1:0]   w_code_nxt;
   logic [CODE_W-1:0]   w_idx;
   logic                w_any;
   logic                w_load;
   logic                w_en;

   assign w_en = sta & ~stb & ~stc;

   // The offered bit is already removed from pend, so selecting straight
   // from pend is the "(pend & ~clr) != 0" test for the next offer.
   prio_sel16 #(
      .LSB_FIRST (LSB_FIRST)
   ) u_prio_sel16 (
      .i_vec (r_pend),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pend  <= '0;
         r_code  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
         r_code  <= w_code_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_code;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_load      = 1'b1;
               w_code_nxt  = w_idx;
               w_state_nxt = OFFER;
            end
         end
         OFFER: begin
            if (ready) begin
               if (w_any) begin
                  w_load     = 1'b1;
                  w_code_nxt = w_idx;
               end else begin
                  w_code_nxt  = '0;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_code_nxt  = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Capture is OR'ed after the clear, so a line held high re-pends the
   // very bit being loaded and fires again.
   assign w_clr      = w_load ? onehot(w_idx) : '0;
   assign w_pend_nxt = (r_pend & ~w_clr) | (req & {N_LINES{w_en}});

   assign code  = r_code;
   assign valid = (r_state == OFFER);
   assign gs    = |r_pend;

endmodule

// File: tb/tb_encoder164_queue.sv
module tb_encoder164_queue;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        sta   = 1'b1;
   logic        stb   = 1'b0;
   logic        stc   = 1'b0;
   logic        ready = 1'b1;
   logic [15:0] req   = '0;

   logic [3:0]  code_l, code_m;
   logic        valid_l, valid_m, gs_l, gs_m;

   int n_chk  = 0;
   int n_fail = 0;

   int exp_l[$];
   int exp_m[$];

   bit         prev_stall [2];
   logic [3:0] prev_code  [2];

   always #5 clk = ~clk;

   encoder164_queue #(.LSB_FIRST(1'b1)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .sta(sta), .stb(stb), .stc(stc), .req(req),
      .code(code_l), .valid(valid_l), .ready(ready), .gs(gs_l)
   );

   encoder164_queue #(.LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .rst_n(rst_n), .sta(sta), .stb(stb), .stc(stc), .req(req),
      .code(code_m), .valid(valid_m), .ready(ready), .gs(gs_m)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push2(input int a, input int b);
      exp_l.push_back(a);
      exp_m.push_back(b);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_l.size() != 0 || exp_m.size() != 0 || valid_l || valid_m) && n < 60) begin
         tick();
         n++;
      end
      chk("drain_in_budget", 32'(n < 60), 1);
   endtask

   // Scoreboard monitor: mid-cycle, a valid&ready pair is a transfer that
   // completes on the coming edge; a valid&!ready pair must hold next cycle.
   always @(negedge clk or negedge rst_n) begin
      logic       v;
      logic [3:0] c;
      int         e;
      if (!rst_n) begin
         prev_stall[0] = 1'b0;
         prev_stall[1] = 1'b0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            v = (k == 0) ? valid_l : valid_m;
            c = (k == 0) ? code_l  : code_m;
            if (prev_stall[k]) begin
               chk("stall_hold_vld", 32'(v), 1);
               chk("stall_hold_code", 32'(c), 32'(prev_code[k]));
            end
            if (!v) begin
               chk("idle_code_zero", 32'(c), 0);
            end else if (ready) begin
               if (k == 0) begin
                  if (exp_l.size() == 0) chk("spurious_offer_lsb", 32'(v), 0);
                  else begin
                     e = exp_l.pop_front();
                     chk("xfer_code_lsb", 32'(c), 32'(e));
                  end
               end else begin
                  if (exp_m.size() == 0) chk("spurious_offer_msb", 32'(v), 0);
                  else begin
                     e = exp_m.pop_front();
                     chk("xfer_code_msb", 32'(c), 32'(e));
                  end
               end
            end
            prev_stall[k] = v && !ready;
            prev_code[k]  = c;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lsb_seq [4];
      int msb_seq [4];
      lsb_seq = '{0, 5, 10, 15};
      msb_seq = '{15, 10, 5, 0};

      // Reset state
      repeat (3) tick();
      chk("rst_valid_lsb", 32'(valid_l), 0);
      chk("rst_code_lsb", 32'(code_l), 0);
      chk("rst_gs_lsb", 32'(gs_l), 0);
      chk("rst_valid_msb", 32'(valid_m), 0);
      chk("rst_code_msb", 32'(code_m), 0);
      chk("rst_gs_msb", 32'(gs_m), 0);
      rst_n = 1'b1;
      tick();

      // Single pulse: latency and return to idle
      ready = 1'b1;
      req = 16'h0001;
      push2(0, 0);
      tick();
      req = '0;
      chk("lat_not_yet_vld", 32'(valid_l), 0);
      chk("lat_gs_pending", 32'(gs_l), 1);
      tick();
      chk("lat_vld", 32'(valid_l), 1);
      chk("lat_code", 32'(code_l), 0);
      tick();
      chk("single_done_vld", 32'(valid_l), 0);
      chk("single_done_gs", 32'(gs_l), 0);
      drain();

      // 8421 burst, both priority directions, back-to-back
      req = 16'h8421;
      for (int i = 0; i < 4; i++) push2(lsb_seq[i], msb_seq[i]);
      tick();
      req = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("burst_vld_lsb", 32'(valid_l), 1);
         chk("burst_code_lsb", 32'(code_l), 32'(lsb_seq[i]));
         chk("burst_vld_msb", 32'(valid_m), 1);
         chk("burst_code_msb", 32'(code_m), 32'(msb_seq[i]));
      end
      tick();
      chk("burst_end_lsb", 32'(valid_l), 0);
      chk("burst_end_msb", 32'(valid_m), 0);
      drain();

      // Backpressure: code 4 held 4 cycles, then 5, then idle
      ready = 1'b0;
      req = 16'h0030;
      push2(4, 5);
      push2(5, 4);
      tick();
      req = '0;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("bp_hold_vld", 32'(valid_l), 1);
         chk("bp_hold_code", 32'(code_l), 4);
         if (i < 3) tick();
      end
      ready = 1'b1;
      tick();
      chk("bp_second_code", 32'(code_l), 5);
      chk("bp_second_code_msb", 32'(code_m), 4);
      tick();
      chk("bp_idle_vld", 32'(valid_l), 0);
      drain();

      // Disabled capture ignores requests
      stb = 1'b1;
      req = 16'hFFFF;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("dis_vld_lsb", 32'(valid_l), 0);
         chk("dis_gs_lsb", 32'(gs_l), 0);
         chk("dis_vld_msb", 32'(valid_m), 0);
         chk("dis_gs_msb", 32'(gs_m), 0);
      end
      stb = 1'b0;
      req = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reen_vld", 32'(valid_l), 0);
         chk("reen_gs", 32'(gs_l), 0);
      end

      // Held line re-fires every cycle
      req = 16'h0008;
      for (int i = 0; i < 6; i++) push2(3, 3);
      tick();
      for (int i = 1; i <= 6; i++) begin
         if (i == 6) req = '0;
         tick();
         chk("held_vld", 32'(valid_l), 1);
         chk("held_code", 32'(code_l), 3);
      end
      tick();
      chk("held_end_vld", 32'(valid_l), 0);
      chk("held_end_gs", 32'(gs_l), 0);
      drain();

      // Enable dropped during offer: pending bits drain, new requests ignored
      req = 16'h0006;
      push2(1, 2);
      push2(2, 1);
      tick();
      sta = 1'b0;
      req = 16'hFFFF;
      drain();
      chk("en_off_gs", 32'(gs_l), 0);
      req = '0;
      sta = 1'b1;
      tick();

      // Async reset mid-offer, then normal sampling right after release
      ready = 1'b0;
      req = 16'h00F8;
      tick();
      req = '0;
      tick();
      chk("pre_rst_vld", 32'(valid_l), 1);
      chk("pre_rst_code_lsb", 32'(code_l), 3);
      chk("pre_rst_code_msb", 32'(code_m), 7);
      chk("pre_rst_gs", 32'(gs_l), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_vld_lsb", 32'(valid_l), 0);
      chk("arst_code_lsb", 32'(code_l), 0);
      chk("arst_gs_lsb", 32'(gs_l), 0);
      chk("arst_vld_msb", 32'(valid_m), 0);
      chk("arst_code_msb", 32'(code_m), 0);
      chk("arst_gs_msb", 32'(gs_m), 0);
      tick();
      rst_n = 1'b1;
      ready = 1'b1;
      req = 16'h0002;
      push2(1, 1);
      tick();
      req = '0;
      chk("post_rst_gs", 32'(gs_l), 1);
      chk("post_rst_no_stale", 32'(valid_l), 0);
      tick();
      chk("post_rst_vld", 32'(valid_l), 1);
      chk("post_rst_code", 32'(code_l), 1);
      drain();
      repeat (3) tick();

      chk("scoreboard_empty", 32'(exp_l.size() + exp_m.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
